// File: rtl/replay_fifo.sv
// ============================================================================
// replay_fifo : multi-lane FIFO with mark/rewind replay of a retained window
// Revision    : 1.0
// ============================================================================
`default_nettype none

module replay_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             wr_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   wr_data,
  input  logic                             rd_en,
  output logic [CHANNELS*DATA_WIDTH-1:0]   rd_data,
  output logic                             rd_valid,
  input  logic                             mark,
  input  logic                             rewind,
  input  logic                             release_mark,
  output logic [ADDR_WIDTH:0]              count,
  output logic                             full,
  output logic                             empty,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int                c_DEPTH    = 1 << ADDR_WIDTH;
  localparam int                c_WORD_W   = CHANNELS * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] c_FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic [ADDR_WIDTH:0] r_mark_ptr;
  logic                r_mark_valid;

  logic [ADDR_WIDTH:0] w_base;
  logic                w_rewind_act;
  logic                w_rd_acc;
  logic                w_wr_acc;
  logic [c_WORD_W-1:0] w_rd_word;

  // While a mark is held, the retained window still occupies space.
  assign w_base = r_mark_valid ? r_mark_ptr : r_rd_ptr;
  assign count  = r_wr_ptr - w_base;
  assign full   = (count == c_FULL_CNT);
  assign empty  = (r_rd_ptr == r_wr_ptr);

  assign w_rewind_act = rewind && r_mark_valid;
  assign w_rd_acc     = !clr && rd_en && !empty && !w_rewind_act;
  // A full FIFO may take a write only if the concurrent read frees a slot.
  assign w_wr_acc     = !clr && wr_en && (!full || (w_rd_acc && !r_mark_valid));

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem [c_DEPTH];

    always_ff @(posedge clk) begin
      if (w_wr_acc) begin
        mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data[g*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign w_rd_word[g*DATA_WIDTH +: DATA_WIDTH] = mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mark_ptr   <= '0;
      r_mark_valid <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (clr) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mark_ptr   <= '0;
      r_mark_valid <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (wr_en && !w_wr_acc) begin
        overflow <= 1'b1;
      end

      rd_valid <= w_rd_acc;
      rd_data  <= w_rd_acc ? w_rd_word : '0;
      if (rd_en && empty && !w_rewind_act) begin
        underflow <= 1'b1;
      end

      // mark samples the read pointer before this cycle's read advances it.
      if (w_rewind_act) begin
        r_rd_ptr <= r_mark_ptr;
      end else begin
        if (w_rd_acc) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
        if (mark) begin
          r_mark_ptr   <= r_rd_ptr;
          r_mark_valid <= 1'b1;
        end else if (release_mark) begin
          r_mark_valid <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/replay_fifo.md
# replay_fifo

Parametrised multi-lane FIFO with mark/rewind replay, successor to the single-lane conv/maxpool line buffer. Buffers CHANNELS lanes of DATA_WIDTH data under one shared pointer set, reports full/empty/occupancy, and lets the conv controller re-read a retained window without the producer rewriting it. Sits between the systolic array output and the maxpool stage.

## Interface
- DATA_WIDTH, 16, bits per lane
- CHANNELS, 4, lanes stored and read in lockstep
- ADDR_WIDTH, 4, address bits; depth is 2**ADDR_WIDTH (16)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of pointers, mark, flags and output
- wr_en  in  1  write request
- wr_data  in  CHANNELS*DATA_WIDTH  write word, lane 0 in LSBs
- rd_en  in  1  read request
- rd_data  out  CHANNELS*DATA_WIDTH  registered read word
- rd_valid  out  1  rd_data holds a word read last cycle
- mark  in  1  capture read pointer as replay start; enable retention
- rewind  in  1  reload read pointer from mark
- release  in  1  end retention; retained space becomes free
- count  out  ADDR_WIDTH+1  occupancy (retained plus unread words)
- full  out  1  count == 2**ADDR_WIDTH
- empty  out  1  no unread word (rd_ptr == wr_ptr)
- overflow  out  1  sticky: write refused
- underflow  out  1  sticky: read refused

## Operation
- Pointers wr_ptr, rd_ptr, mark_ptr are ADDR_WIDTH+1 bits (wrap bit); memory indexed by low ADDR_WIDTH bits; all arithmetic modulo 2**(ADDR_WIDTH+1).
- base = mark_valid ? mark_ptr : rd_ptr; count = wr_ptr - base.
- Write accepted when wr_en and (!full, or full and a read is accepted this cycle and mark_valid=0). Accepted write stores wr_data at wr_ptr, wr_ptr+1. Refused write sets overflow; memory and pointers unchanged.
- Read accepted when rd_en and !empty and rewind=0: rd_data <= mem[rd_ptr], rd_valid<=1, rd_ptr+1. Otherwise rd_data<=0, rd_valid<=0. rd_en while empty (and rewind=0) sets underflow.
- While mark_valid, reads do not free space: full and count track from mark_ptr.
- mark: mark_ptr <= rd_ptr (value before any read this cycle), mark_valid<=1. Re-mark while valid moves mark_ptr.
- rewind: if mark_valid, rd_ptr <= mark_ptr; read that cycle suppressed (no underflow). If !mark_valid, ignored and rd_en is handled normally.
- release: mark_valid<=0.
- Per-cycle priority: clr > rewind > mark > release; writes are independent of rewind/mark/release except through full.
- clr: wr_ptr, rd_ptr, mark_ptr, mark_valid, rd_data, rd_valid, overflow, underflow to 0; memory untouched; all other inputs ignored that cycle.
- No combinational path from any input to any output; count/full/empty decode registered pointers only.

## Timing
- Reset (rst_n low, async): all pointers 0, mark_valid 0, rd_data 0, rd_valid 0, overflow 0, underflow 0 -> count 0, full 0, empty 1. Memory not reset.
- Read latency 1: rd_en accepted at edge N, rd_data/rd_valid valid after edge N, for one cycle only.
- Write-to-read: word written at edge N is readable (empty falls) after edge N; earliest rd_data after edge N+1.
- Flags update after the edge that changes pointers.
- Reset asserted mid-burst aborts immediately; in-flight read data discarded (rd_valid 0).
- Pointer wrap: after 2**ADDR_WIDTH writes, low bits wrap to 0, wrap bit toggles; full/empty distinguish by wrap bit.

## Test plan
- Fill/drain: write 16 words 0x1..0x10 per lane -> full=1, count=16; read 16 -> data in order, 1-cycle latency, empty=1, rd_data=0 on idle cycles.
- Overflow/underflow: 17th write while full -> overflow=1, count stays 16; read while empty -> underflow=1, rd_valid=0; clr -> both 0, count 0.
- Replay: write 9, mark, read 9, rewind, read 9 -> identical second sequence; count=9 throughout; release -> count 0, empty=1.
- Retention blocks space: mark at rd_ptr=0, write 16, read 4 -> full stays 1, write refused (overflow); release -> count 12, full 0.
- Simultaneous: full, mark_valid=0, wr_en+rd_en same cycle -> both accepted, count 16; same with rewind+rd_en -> read suppressed, rd_valid 0, no underflow.
- Wrap and reset: 40 write/read pairs -> data intact across wrap; rst_n low mid-stream -> outputs at reset values asynchronously, next 16 writes accepted.
